// File: rtl/timer_sequencer.sv
// timer_sequencer: queues delay commands in a small FIFO and runs them one at
// a time on the 0.1 s delay timer, reporting completion and abort upstream.
//   cmd_valid/cmd_ready/cmd_delay : command intake (push on valid & ready)
//   abort                         : flush queue, stop timer (highest priority)
//   timer_start/timer_delay/timer_reset, timer_done : timer interface
//   step_done, aborted            : one-cycle status pulses
//   busy, fifo_level, err_spurious, seq_state : status / debug
module timer_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DELAY_WIDTH = 8,
    parameter int unsigned LEVEL_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DELAY_WIDTH-1:0] cmd_delay,
    input  logic                   abort,
    output logic                   timer_start,
    output logic [DELAY_WIDTH-1:0] timer_delay,
    output logic                   timer_reset,
    input  logic                   timer_done,
    output logic                   step_done,
    output logic                   aborted,
    output logic                   busy,
    output logic [LEVEL_WIDTH-1:0] fifo_level,
    output logic                   err_spurious,
    output logic [1:0]             seq_state
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_e;

    state_e                 state_q;
    logic [DELAY_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   timer_start_q;
    logic [DELAY_WIDTH-1:0] timer_delay_q;
    logic                   timer_reset_q;
    logic                   step_done_q;
    logic                   aborted_q;
    logic                   err_q;

    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic [DELAY_WIDTH-1:0] head;

    // Intake handshake: abort blocks intake so nothing survives the flush.
    assign cmd_ready  = (level_q < LEVEL_WIDTH'(DEPTH)) && !abort;
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (level_q == '0);
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q];

    // FIFO pointer/level next-state; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LEVEL_WIDTH'(1);
        end else if (pop && !push) begin
            level_d = level_q - LEVEL_WIDTH'(1);
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_delay;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            timer_start_q <= 1'b0;
            timer_delay_q <= '0;
            timer_reset_q <= 1'b0;
            step_done_q   <= 1'b0;
            aborted_q     <= 1'b0;
            err_q         <= 1'b0;
        end else if (abort) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            timer_start_q <= 1'b0;
            timer_reset_q <= 1'b1;
            step_done_q   <= 1'b0;
            aborted_q     <= 1'b1;
            err_q         <= 1'b0;
        end else begin
            timer_start_q <= 1'b0;
            timer_reset_q <= 1'b0;
            step_done_q   <= 1'b0;
            aborted_q     <= 1'b0;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            if (timer_done && (state_q != S_WAIT)) begin
                err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        timer_delay_q <= head;
                        // A zero delay would run the timer a full wrap; retire it here.
                        if (head == '0) begin
                            step_done_q <= 1'b1;
                        end else begin
                            state_q <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    timer_start_q <= 1'b1;
                    state_q       <= S_WAIT;
                end
                S_WAIT: begin
                    if (timer_done) begin
                        step_done_q <= 1'b1;
                        state_q     <= S_GAP;
                    end
                end
                S_GAP: begin
                    // Lets the timer drop back to idle before the next launch.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign timer_start  = timer_start_q;
    assign timer_delay  = timer_delay_q;
    assign timer_reset  = timer_reset_q;
    assign step_done    = step_done_q;
    assign aborted      = aborted_q;
    assign err_spurious = err_q;
    assign fifo_level   = level_q;
    assign seq_state    = state_q;
    assign busy         = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_timer_sequencer.sv
// Randomized bench for timer_sequencer: a transaction-level reference model
// predicts start/step/abort events into queues and a negedge monitor pops and
// compares them, together with per-cycle status checks.
module tb_timer_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned LW    = 3;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_delay;
    logic          abort;
    logic          timer_start;
    logic [DW-1:0] timer_delay;
    logic          timer_reset;
    logic          timer_done;
    logic          step_done;
    logic          aborted;
    logic          busy;
    logic [LW-1:0] fifo_level;
    logic          err_spurious;
    logic [1:0]    seq_state;

    timer_sequencer #(.DEPTH(DEPTH), .DELAY_WIDTH(DW), .LEVEL_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_delay(cmd_delay),
        .abort(abort),
        .timer_start(timer_start), .timer_delay(timer_delay),
        .timer_reset(timer_reset), .timer_done(timer_done),
        .step_done(step_done), .aborted(aborted), .busy(busy),
        .fifo_level(fifo_level), .err_spurious(err_spurious),
        .seq_state(seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (edge-indexed) ----------------
    logic [DW-1:0] mq[$];          // queued delays
    logic [DW-1:0] exp_start_q[$]; // delay expected on a start pulse this cycle
    int            exp_step_q[$];
    int            exp_abort_q[$];
    int            cyc       = 0;
    int            free_at   = 0;  // first edge at which a pop may happen
    int            wait_from = 0;  // first edge at which timer_done counts as real
    int            start_cyc = 0;
    int            reset_edge = -1;
    bit            running   = 0;
    bit            start_pend = 0;
    bit            m_err     = 0;
    logic [DW-1:0] cur_delay = '0;

    initial begin
        int            nb;
        logic [DW-1:0] d;
        forever begin
            @(posedge clk);
            cyc++;
            nb = mq.size();
            if (!reset_n) begin
                mq.delete();
                running = 0; start_pend = 0; m_err = 0;
                free_at = cyc + 1; reset_edge = cyc;
            end else if (abort) begin
                mq.delete();
                running = 0; start_pend = 0; m_err = 0;
                free_at = cyc + 1;
                exp_abort_q.push_back(cyc);
            end else begin
                if (start_pend && start_cyc == cyc) begin
                    exp_start_q.push_back(cur_delay);
                    start_pend = 0;
                end
                if (timer_done) begin
                    if (running && cyc >= wait_from) begin
                        running = 0;
                        exp_step_q.push_back(cyc);
                        free_at = cyc + 2;
                    end else begin
                        m_err = 1;
                    end
                end
                if (!running && cyc >= free_at && mq.size() > 0) begin
                    d = mq.pop_front();
                    if (d == '0) begin
                        exp_step_q.push_back(cyc);
                        free_at = cyc + 1;
                    end else begin
                        running = 1; cur_delay = d;
                        start_pend = 1; start_cyc = cyc + 1; wait_from = cyc + 2;
                    end
                end
                if (cmd_valid && nb < int'(DEPTH)) mq.push_back(cmd_delay);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit            has;
        logic [DW-1:0] d;
        int            tmp;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                check("fifo_level", int'(fifo_level), mq.size());
                check("err_spurious", int'(err_spurious), int'(m_err));
                check("busy", int'(busy),
                      int'(running || mq.size() > 0 || (cyc + 1 < free_at)));
                check("cmd_ready", int'(cmd_ready),
                      int'(mq.size() < int'(DEPTH) && !abort));
                if (running) check("timer_delay_hold", int'(timer_delay), int'(cur_delay));
                if (reset_edge == cyc) begin
                    check("reset_state", int'(seq_state), 0);
                    check("reset_delay", int'(timer_delay), 0);
                end
                has = exp_start_q.size() > 0;
                check("timer_start", int'(timer_start), int'(has));
                if (has) begin
                    d = exp_start_q.pop_front();
                    if (timer_start) check("start_delay", int'(timer_delay), int'(d));
                end
                has = exp_step_q.size() > 0;
                check("step_done", int'(step_done), int'(has));
                if (has) tmp = exp_step_q.pop_front();
                has = exp_abort_q.size() > 0;
                check("aborted", int'(aborted), int'(has));
                check("timer_reset", int'(timer_reset), int'(has));
                if (has) tmp = exp_abort_q.pop_front();
            end
        end
    end

    // ---------------- driver + timer emulator ----------------
    int cd         = 0;
    int abort_hold = 0;

    task automatic tick(input int p_valid, input int p_zero, input int p_abort,
                        input int p_spur, input int lat_min, input int lat_max,
                        input bit do_rst);
        @(posedge clk);
        #1;
        timer_done = 1'b0;
        if (!reset_n || timer_reset) begin
            cd = 0;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) timer_done = 1'b1;
        end
        if (timer_start) cd = int'($urandom_range(lat_max, lat_min));
        if (cd == 0 && int'($urandom_range(99, 0)) < p_spur) timer_done = 1'b1;
        if (abort_hold > 0) begin
            abort = 1'b1;
            abort_hold--;
        end else if (int'($urandom_range(99, 0)) < p_abort ||
                     (timer_done && int'($urandom_range(99, 0)) < p_abort * 10)) begin
            abort = 1'b1;
            abort_hold = int'($urandom_range(2, 0));
        end else begin
            abort = 1'b0;
        end
        cmd_valid = (int'($urandom_range(99, 0)) < p_valid);
        cmd_delay = (int'($urandom_range(99, 0)) < p_zero) ? '0 : DW'($urandom_range(255, 1));
        reset_n   = !do_rst;
    endtask

    initial begin
        int next_rst;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_delay = '0;
        abort = 1'b0; timer_done = 1'b0;
        repeat (3) @(posedge clk);
        // light traffic, short timer
        for (int t = 0; t < 500; t++) tick(30, 15, 0, 0, 1, 4, 1'b0);
        // heavy traffic, long timer: FIFO fills; occasional reset mid-WAIT
        next_rst = 100;
        for (int t = 0; t < 500; t++) begin
            if (t >= next_rst && cd > 2) begin
                tick(80, 5, 0, 0, 10, 25, 1'b1);
                next_rst = t + 120;
            end else begin
                tick(80, 5, 0, 0, 10, 25, 1'b0);
            end
        end
        // aborts (some coinciding with done) and spurious done pulses
        for (int t = 0; t < 600; t++) tick(50, 10, 3, 3, 1, 8, 1'b0);
        // mostly zero-delay commands
        for (int t = 0; t < 300; t++) tick(60, 60, 1, 1, 1, 3, 1'b0);
        // drain
        for (int t = 0; t < 60; t++) tick(0, 0, 0, 0, 1, 3, 1'b0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Upstream controller for the 0.1 s-resolution delay timer in the executor.
- Buffers delay commands from the executor's command stage in a small FIFO and dispatches them one at a time to the timer.
- Drives the timer's start, delay and synchronous reset inputs; consumes the timer's done pulse.
- Reports per-step completion and abort back to the command stage.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, 2..16)
DELAY_WIDTH, 8, delay field width in 0.1 s units; equals the timer delay width
LEVEL_WIDTH, 3, width of fifo_level; must hold DEPTH

Ports:
clk  in  1  master clock, 50 MHz
reset_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept a command
cmd_delay  in  DELAY_WIDTH  delay of offered command, units of 0.1 s
abort  in  1  flush queue and stop running timer
timer_start  out  1  start pulse to timer
timer_delay  out  DELAY_WIDTH  delay to timer; held stable while timer runs
timer_reset  out  1  synchronous reset pulse to timer
timer_done  in  1  one-cycle done pulse from timer
step_done  out  1  one-cycle pulse per completed command
aborted  out  1  one-cycle pulse acknowledging abort
busy  out  1  high when state != IDLE or FIFO not empty
fifo_level  out  LEVEL_WIDTH  number of queued commands
err_spurious  out  1  sticky: timer_done seen outside WAIT
seq_state  out  2  current state, for debug

Behaviour:
- All outputs registered except cmd_ready and busy, which are combinational from registered state and level.
- On reset_n low at a clk edge: state IDLE, FIFO empty, all outputs 0, timer_delay 0.
- cmd_ready = (fifo_level < DEPTH) and not abort.
  - Push occurs when cmd_valid and cmd_ready.
  - A push at full is impossible by definition; a push during abort is dropped.
- Push and pop in the same cycle leave the level unchanged. Pointers wrap modulo DEPTH.
- States:
  - IDLE (0):
    - If FIFO not empty: pop head and load timer_delay.
    - If the popped delay == 0: pulse step_done next cycle and stay in IDLE. The timer must never be started with 0, because it would run 256 units.
    - Otherwise go to LAUNCH.
  - LAUNCH (1): timer_start = 1 for exactly this one cycle; go to WAIT.
  - WAIT (2): hold timer_delay. On timer_done: pulse step_done next cycle and go to GAP.
  - GAP (3): one idle cycle so the timer settles back to idle and clears done; then go to IDLE.
- Latency:
  - Push into an empty FIFO while IDLE: timer_start rises 2 cycles after the push edge.
  - step_done rises 1 cycle after timer_done.
  - Back-to-back nonzero commands: 3 cycles from timer_done to the next timer_start.
- abort (any state, highest priority):
  - Next cycle: timer_reset = 1 and aborted = 1, each for one cycle.
  - FIFO is flushed, level 0, state IDLE, err_spurious cleared, timer_start 0.
  - abort held for several cycles: pulses repeat each cycle; the queue stays empty.
- abort and timer_done in the same cycle: abort wins and step_done is not pulsed.
- timer_done while not in WAIT sets err_spurious. It is cleared only by reset_n or abort, and the state is unaffected.
- reset_n mid-run: timer_reset is not pulsed. The system-level reset also resets the timer.

Test Plan:
- Push delay 3 into empty IDLE -> timer_start is one pulse 2 cycles later with timer_delay = 3; timer_done injected -> step_done 1 cycle later; busy falls after GAP.
- Push delays 1, 0, 2 back-to-back ->
  - First: start with delay 1, then step_done after done.
  - Second (0): step_done without timer_start.
  - Third: start with delay 2 exactly 3 cycles after the first timer_done excluding the zero step.
  - 3 step_done pulses total.
- Push 5 commands with DEPTH = 4 while in WAIT -> cmd_ready low after the 4th; 5th held until a pop; fifo_level reaches 4.
- Abort while in WAIT with 2 queued -> timer_reset = 1 and aborted = 1 for one cycle; level 0; IDLE; a later timer_done sets err_spurious.
- abort and timer_done in the same cycle -> no step_done, aborted = 1; a cmd_valid in that cycle is not accepted.
- reset_n low for 1 cycle mid-WAIT -> all outputs 0, FIFO empty, state IDLE on the next edge.
